// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-column-low strobing, per-key debounce, live keymap
// and a press/release event FIFO with a registered head and sticky overflow flag.
module keypad_scanner #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned KW             = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                   fpga_clk,
  input  logic                   rst_in,
  input  logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        col,
  output logic [ROWS*COLS-1:0]   keymap,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_pressed,
  output logic [KW-1:0]          evt_key,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int unsigned NK  = ROWS * COLS;
  localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned DVW = $clog2(SCAN_DIV);
  localparam int unsigned DCW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW  = KW + 1;

  // Events of one tick drain one per cycle; they must be gone before the next tick.
  if (SCAN_DIV < ROWS || SCAN_DIV < 2) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= ROWS and >= 2");
  end

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  logic [ROWS-1:0]    row_meta_q, row_sync_q;
  logic [DVW-1:0]     div_q, div_d;
  logic [CIW-1:0]     col_idx_q, col_idx_d;
  logic [COLS-1:0]    col_q, col_d;
  logic               tick;
  logic [NK-1:0]      keymap_q, keymap_d;
  logic [DCW-1:0]     cnt_q [NK];
  logic [DCW-1:0]     cnt_d [NK];
  logic [KW-1:0]      k;
  logic [ROWS-1:0]    new_ev, new_val;
  logic [ROWS-1:0]    pend_q, pend_d, pend_val_q, pend_val_d;
  logic [CIW-1:0]     pend_col_q, pend_col_d;
  logic [ROWS-1:0]    src, src_val;
  logic [CIW-1:0]     src_col;
  logic [RIW-1:0]     sel;
  logic               push;
  logic [EW-1:0]      push_data;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FCW-1:0]     count_q, count_d, remain;
  logic               pop, full, accept, drop;
  logic               evt_valid_q, evt_valid_d, evt_pressed_q, evt_pressed_d;
  logic [KW-1:0]      evt_key_q, evt_key_d;
  logic [EW-1:0]      head_nxt;
  logic               ovf_q, ovf_d;

  // Reset: asserts asynchronously, releases on the second clock edge.
  always_ff @(posedge fpga_clk or negedge rst_in) begin
    if (!rst_in) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Scan divider and column strobe.
  always_comb begin
    tick      = (div_q == DVW'(SCAN_DIV - 1));
    div_d     = tick ? '0 : div_q + DVW'(1);
    col_idx_d = col_idx_q;
    if (tick) col_idx_d = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + CIW'(1);
    col_d     = ~(COLS'(1) << col_idx_d);
  end

  // Debounce the ROWS keys of the current column on each tick.
  always_comb begin
    keymap_d = keymap_q;
    cnt_d    = cnt_q;
    new_ev   = '0;
    new_val  = '0;
    k        = '0;
    if (tick) begin
      for (int r = 0; r < ROWS; r++) begin
        k = KW'(r * COLS) + KW'(col_idx_q);
        if (!row_sync_q[r] == keymap_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == DCW'(DEBOUNCE_SCANS - 1)) begin
          cnt_d[k]    = '0;
          keymap_d[k] = !keymap_q[k];
          new_ev[r]   = 1'b1;
          new_val[r]  = !row_sync_q[r];
        end else begin
          cnt_d[k] = cnt_q[k] + DCW'(1);
        end
      end
    end
  end

  // Lowest-row event goes straight in on the tick; the rest drain from pend_q.
  always_comb begin
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_col_d = pend_col_q;
    push       = 1'b0;
    push_data  = '0;
    src        = pend_q;
    src_val    = pend_val_q;
    src_col    = pend_col_q;
    sel        = '0;
    if (tick && (|new_ev)) begin
      src     = new_ev;
      src_val = new_val;
      src_col = col_idx_q;
    end
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (src[r]) sel = RIW'(r);
    end
    if (|src) begin
      push       = 1'b1;
      push_data  = {src_val[sel], KW'(sel) * KW'(COLS) + KW'(src_col)};
      pend_d     = src & ~(ROWS'(1) << sel);
      pend_val_d = src_val;
      pend_col_d = src_col;
    end
  end

  // Event FIFO with a registered copy of the next head.
  always_comb begin
    pop      = evt_valid_q && evt_ready;
    full     = (count_q == FCW'(FIFO_DEPTH));
    accept   = push && (!full || pop);
    drop     = push && full && !pop;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    remain   = pop ? count_q - FCW'(1) : count_q;
    count_d  = accept ? remain + FCW'(1) : remain;
    head_nxt = (remain == '0) ? push_data : mem_q[rd_ptr_d];
    evt_valid_d   = (count_d != '0);
    evt_pressed_d = evt_pressed_q;
    evt_key_d     = evt_key_q;
    if (evt_valid_d) begin
      evt_pressed_d = head_nxt[EW-1];
      evt_key_d     = head_nxt[KW-1:0];
    end
    ovf_d = (ovf_q && !ovf_clr) || drop;
  end

  always_ff @(posedge fpga_clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q    <= '1;
      row_sync_q    <= '1;
      div_q         <= '0;
      col_idx_q     <= '0;
      col_q         <= ~COLS'(1);
      keymap_q      <= '0;
      cnt_q         <= '{default: '0};
      pend_q        <= '0;
      pend_val_q    <= '0;
      pend_col_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      evt_valid_q   <= 1'b0;
      evt_pressed_q <= 1'b0;
      evt_key_q     <= '0;
      ovf_q         <= 1'b0;
    end else begin
      row_meta_q    <= row;
      row_sync_q    <= row_meta_q;
      div_q         <= div_d;
      col_idx_q     <= col_idx_d;
      col_q         <= col_d;
      keymap_q      <= keymap_d;
      cnt_q         <= cnt_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      pend_col_q    <= pend_col_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      evt_valid_q   <= evt_valid_d;
      evt_pressed_q <= evt_pressed_d;
      evt_key_q     <= evt_key_d;
      ovf_q         <= ovf_d;
    end
  end

  assign col         = col_q;
  assign keymap      = keymap_q;
  assign evt_valid   = evt_valid_q;
  assign evt_pressed = evt_pressed_q;
  assign evt_key     = evt_key_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a key-matrix model drives row from col,
// expected events are queued as keys change and checked as the FIFO delivers them.
module tb_keypad_scanner;

  logic        fpga_clk = 1'b0;
  logic        rst_in;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keymap;
  logic        evt_valid, evt_ready, evt_pressed, ovf, ovf_clr;
  logic [3:0]  evt_key;
  logic [15:0] keys;
  logic [4:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3), .FIFO_DEPTH(4)
  ) dut (
    .fpga_clk    (fpga_clk),
    .rst_in      (rst_in),
    .row         (row),
    .col         (col),
    .keymap      (keymap),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_pressed (evt_pressed),
    .evt_key     (evt_key),
    .ovf         (ovf),
    .ovf_clr     (ovf_clr)
  );

  always #5 fpga_clk = ~fpga_clk;

  // Key matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every accepted event must match the oldest queued expectation.
  always @(negedge fpga_clk) begin
    logic [4:0] e;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      chk("evt_expected_any", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("evt_payload", 32'({evt_pressed, evt_key}), 32'(e));
      end
    end
  end

  // Wait until column c has been sampled n more times (its strobe rises), bounded.
  task automatic wait_col_rise(input int c, input int n);
    int   seen = 0;
    int   cyc  = 0;
    logic prev;
    prev = col[c];
    while (seen < n && cyc < 500) begin
      @(negedge fpga_clk);
      cyc++;
      if (prev === 1'b0 && col[c] === 1'b1) seen++;
      prev = col[c];
    end
    chk("col_sample_wait", 32'(seen), 32'(n));
  endtask

  initial begin
    logic [3:0] exp_col;
    int         cyc;
    rst_in    = 1'b0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    keys      = '0;

    // Reset state
    repeat (3) @(negedge fpga_clk);
    chk("rst_col", 32'(col), 32'h0000_000E);
    chk("rst_keymap", 32'(keymap), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_evt_key", 32'(evt_key), 32'd0);
    chk("rst_evt_pressed", 32'(evt_pressed), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Idle scan: 1110,1101,1011,0111 with four cycles per column
    rst_in = 1'b1;
    cyc = 0;
    while (col !== 4'b1101 && cyc < 20) begin
      @(negedge fpga_clk);
      cyc++;
    end
    chk("scan_start", 32'(col), 32'h0000_000D);
    for (int s = 0; s < 12; s++) begin
      exp_col = ~(4'b0001 << ((s + 1) % 4));
      for (int j = 0; j < 4; j++) begin
        chk("scan_col", 32'(col), 32'(exp_col));
        chk("scan_keymap", 32'(keymap), 32'd0);
        chk("scan_evt_valid", 32'(evt_valid), 32'd0);
        @(negedge fpga_clk);
      end
    end
    repeat (152) begin
      chk("idle_evt_valid", 32'(evt_valid), 32'd0);
      @(negedge fpga_clk);
    end
    chk("idle_keymap", 32'(keymap), 32'd0);

    // Debounced press of key 6 (row 1, col 2)
    wait_col_rise(2, 1);
    keys[6] = 1'b1;
    exp_q.push_back({1'b1, 4'd6});
    wait_col_rise(2, 2);
    chk("press6_after2", 32'(keymap), 32'd0);
    wait_col_rise(2, 1);
    chk("press6_keymap", 32'(keymap), 32'h0000_0040);
    chk("press6_valid", 32'(evt_valid), 32'd1);
    chk("press6_head", 32'({evt_pressed, evt_key}), 32'h0000_0016);

    // Release after a valid press
    keys[6] = 1'b0;
    exp_q.push_back({1'b0, 4'd6});
    wait_col_rise(2, 3);
    chk("release6_keymap", 32'(keymap), 32'd0);

    // Bounce: two samples low, one high, two low, then released
    keys[6] = 1'b1;
    wait_col_rise(2, 2);
    keys[6] = 1'b0;
    wait_col_rise(2, 1);
    keys[6] = 1'b1;
    wait_col_rise(2, 2);
    chk("bounce_keymap_mid", 32'(keymap), 32'd0);
    keys[6] = 1'b0;
    wait_col_rise(2, 3);
    chk("bounce_keymap", 32'(keymap), 32'd0);
    chk("bounce_queue", 32'(exp_q.size()), 32'd0);

    // Four keys in column 0 debounce on the same tick
    wait_col_rise(0, 1);
    keys = 16'h1111;
    exp_q.push_back({1'b1, 4'd0});
    exp_q.push_back({1'b1, 4'd4});
    exp_q.push_back({1'b1, 4'd8});
    exp_q.push_back({1'b1, 4'd12});
    wait_col_rise(0, 3);
    chk("multi_keymap", 32'(keymap), 32'h0000_1111);
    chk("multi_first", 32'({evt_valid, evt_pressed, evt_key}), 32'h0000_0030);
    keys = 16'h0000;
    exp_q.push_back({1'b0, 4'd0});
    exp_q.push_back({1'b0, 4'd4});
    exp_q.push_back({1'b0, 4'd8});
    exp_q.push_back({1'b0, 4'd12});
    wait_col_rise(0, 3);
    chk("multi_release_keymap", 32'(keymap), 32'd0);
    repeat (8) @(negedge fpga_clk);
    chk("multi_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: five presses into a four-entry FIFO
    @(posedge fpga_clk); #1 evt_ready = 1'b0;
    wait_col_rise(0, 1);
    keys = 16'h2226;
    exp_q.push_back({1'b1, 4'd1});
    exp_q.push_back({1'b1, 4'd5});
    exp_q.push_back({1'b1, 4'd9});
    exp_q.push_back({1'b1, 4'd13});
    wait_col_rise(2, 3);
    chk("bp_keymap", 32'(keymap), 32'h0000_2226);
    chk("bp_ovf", 32'(ovf), 32'd1);
    repeat (3) begin
      chk("bp_head_hold", 32'({evt_valid, evt_pressed, evt_key}), 32'h0000_0031);
      @(negedge fpga_clk);
    end
    @(posedge fpga_clk); #1 ovf_clr = 1'b1;
    @(posedge fpga_clk); #1 ovf_clr = 1'b0;
    @(negedge fpga_clk);
    chk("bp_ovf_clr", 32'(ovf), 32'd0);
    @(posedge fpga_clk); #1 evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge fpga_clk);
      chk("bp_drain_valid", 32'(evt_valid), 32'd1);
    end
    @(negedge fpga_clk);
    chk("bp_drain_empty", 32'(evt_valid), 32'd0);
    chk("bp_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between the second and third sample of a press
    wait_col_rise(2, 1);
    keys = 16'h0040;
    wait_col_rise(2, 2);
    @(posedge fpga_clk); #2 rst_in = 1'b0;
    #1;
    chk("arst_col", 32'(col), 32'h0000_000E);
    chk("arst_keymap", 32'(keymap), 32'd0);
    chk("arst_evt_valid", 32'(evt_valid), 32'd0);
    chk("arst_ovf", 32'(ovf), 32'd0);
    keys = 16'h0000;
    repeat (3) @(negedge fpga_clk);
    rst_in = 1'b1;
    repeat (200) begin
      @(negedge fpga_clk);
      chk("arst_quiet", 32'({evt_valid, keymap}), 32'd0);
    end
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
